spi_frame_buffer: RTL and testbench
===================================

Name: spi_frame_buffer

Overview:
- Parametrised SPI slave that collects one audio frame (NUM_SAMPLES words) from the master into on-chip sample memory.
- Exposes the frame to the matching/processing logic through a registered read port.
- Shifts a single result word back to the master on the next select.
- Runs entirely in the system clk domain: sck, sdi and ss are synchronised and edge-detected, so no logic is clocked by sck.

Parameters:
- WORD_W, 32: SPI word length in bits (≥ SAMPLE_W, ≥ 2).
- SAMPLE_W, 10: low bits of each received word stored as a sample.
- NUM_SAMPLES, 2000: words per frame (≥ 1).
- ADDR_W, 11: sample address width; must satisfy 2^ADDR_W ≥ NUM_SAMPLES.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from master, asynchronous; period ≥ 8 clk.
- sdi  in  1  SPI data from master.
- ss  in  1  slave select, active-high (high = frame/transfer in progress).
- sdo  out  1  SPI data to master.
- abort  in  1  synchronous return to IDLE from any state.
- rd_addr  in  ADDR_W  sample read address.
- rd_data  out  SAMPLE_W  sample at rd_addr, one clk latency.
- input_ready  out  1  high while a complete frame is held (HOLD).
- result_valid  in  1  one-clk strobe: result_word is final.
- result_word  in  WORD_W  word to return to master.
- word_cnt  out  ADDR_W+1  samples stored in current frame.
- frame_err  out  1  sticky: ss dropped mid-word; cleared on entry to RECV.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Synchronisers: sck, sdi and ss each pass through 2 flops. Rising and falling edges are detected on the synchronised copies using a third flop. All references below to sck/ss edges mean these detected events.
- States and encodings: IDLE=000, RECV=001, HOLD=010, ARM=011, XMIT=100. Reset value is IDLE.
- IDLE:
  - ss rise → RECV.
  - Clear bit_cnt and word_cnt, clear frame_err.
- RECV:
  - Each sck rise: shift_in ← {shift_in[WORD_W-2:0], sdi}; bit_cnt+1.
  - On the rise that completes bit WORD_W-1: write the new word's [SAMPLE_W-1:0] to mem[word_cnt]; word_cnt+1; bit_cnt ← 0.
  - When word_cnt reaches NUM_SAMPLES → HOLD on the next clk. This is independent of ss.
  - ss fall with bit_cnt ≠ 0: partial word discarded, bit_cnt ← 0, frame_err ← 1, remain in RECV. Stored words are kept and the next ss rise continues at word_cnt.
  - ss fall with bit_cnt = 0: no error, remain in RECV.
  - sck edges while ss is low are ignored.
- HOLD:
  - input_ready = 1; memory is frozen and writes are blocked.
  - result_valid → latch result_word into tx_word → ARM.
  - result_valid in any other state is ignored.
- ARM: waits for ss low then high (a full ss rise event); on ss rise → XMIT, shift_out ← tx_word, bit_cnt ← 0.
- XMIT:
  - sdo = shift_out[WORD_W-1].
  - Each sck fall: shift_out shifts left with 0 fill; bit_cnt+1.
  - Once bit_cnt = WORD_W, or on ss fall, whichever is first → IDLE.
  - sdo is driven 0 in every state except XMIT.
- Latency:
  - The first sdo bit is valid 3 clk after the raw ss rise.
  - Later bits change ≤ 4 clk after the raw sck fall. This is valid for the master's sample on the next sck rise because the sck period is ≥ 8 clk.
- Memory: NUM_SAMPLES × SAMPLE_W, single write port and single registered read port. rd_data ← mem[rd_addr] every clk in all states.
  - An out-of-range rd_addr (≥ NUM_SAMPLES) returns 0.
  - Memory contents are not reset.
- Simultaneous events:
  - abort has priority over everything → IDLE.
  - In HOLD, result_valid and ss rise in the same clk → ARM; that ss rise is not consumed.
- Reset mid-operation: every register returns to its reset value immediately. Outputs after reset: sdo=0, input_ready=0, rd_data=0, word_cnt=0, frame_err=0, state_dbg=000.

Test Plan:
- Full frame, NUM_SAMPLES=4, WORD_W=32: send 0x0000_0155, 0x3FF, 0x0, 0xFFFF_F001 → input_ready=1 and word_cnt=4. Reading rd_addr 0..3 returns 0x155, 0x3FF, 0x000, 0x001, each 1 clk after the address is presented.
- Result return: in HOLD pulse result_valid with result_word=0x0000_02AA, toggle ss, clock 32 bits → master receives 0x0000_02AA MSB-first; state returns to IDLE (000).
- Mid-word ss drop: send 13 bits, drop ss → frame_err=1 and word_cnt unchanged. Re-raise ss, send 4 full words → frame completes with the correct 4 samples.
- Reset during RECV after 2 words → all outputs at reset values. A new frame then stores from address 0.
- abort asserted in XMIT after 5 bits → IDLE next clk and sdo=0. A result_valid strobe in IDLE is ignored (state stays 000).
- Sync margin: sck period = 8 clk with sdi changing 1 clk after sck fall → no bit errors over 4 words. Also check SAMPLE_W=16, WORD_W=16 parametrisation.

Source files
------------

// File: rtl/spi_frame_buffer.sv
// SPI slave that captures one frame of samples into local memory, holds it for
// the processing logic, then returns a single result word on the next select.
module spi_frame_buffer #(
  parameter int WORD_W      = 32,
  parameter int SAMPLE_W    = 10,
  parameter int NUM_SAMPLES = 2000,
  parameter int ADDR_W      = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                sdi,
  input  logic                ss,
  output logic                sdo,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                input_ready,
  input  logic                result_valid,
  input  logic [WORD_W-1:0]   result_word,
  output logic [ADDR_W:0]     word_cnt,
  output logic                frame_err,
  output logic [2:0]          state_dbg
);

  localparam int BIT_W  = $clog2(WORD_W + 1);
  localparam int MEM_AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0]  BIT_FULL = BIT_W'(WORD_W);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(NUM_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_RECV = 3'b001,
    S_HOLD = 3'b010,
    S_ARM  = 3'b011,
    S_XMIT = 3'b100
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            sck_sync_q, sck_sync_d;
  logic [2:0]            ss_sync_q, ss_sync_d;
  logic [1:0]            sdi_sync_q, sdi_sync_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]       word_cnt_q, word_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic [SAMPLE_W-2:0]   shift_in_q, shift_in_d;
  logic [WORD_W-1:0]     shift_out_q, shift_out_d;
  logic [WORD_W-1:0]     tx_word_q, tx_word_d;
  logic                  sdo_q, sdo_d;
  logic                  input_ready_q, input_ready_d;
  logic [SAMPLE_W-1:0]   rd_data_q, rd_data_d;
  logic [SAMPLE_W-1:0]   mem_q [NUM_SAMPLES];

  logic                  sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s, ss_hi_s;
  logic                  mem_we_s;
  logic [SAMPLE_W-1:0]   mem_wdata_s;

  assign sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s  = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_rise_s   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall_s   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_hi_s     = ss_sync_q[1];
  // Only the low SAMPLE_W bits of a word ever reach memory, so older bits are not kept.
  assign mem_wdata_s = {shift_in_q, sdi_sync_q[1]};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    sck_sync_d    = {sck_sync_q[1:0], sck};
    ss_sync_d     = {ss_sync_q[1:0], ss};
    sdi_sync_d    = {sdi_sync_q[0], sdi};
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    frame_err_d   = frame_err_q;
    shift_in_d    = shift_in_q;
    shift_out_d   = shift_out_q;
    tx_word_d     = tx_word_q;
    mem_we_s      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_d   = {BIT_W{1'b0}};
          word_cnt_d  = {(ADDR_W + 1){1'b0}};
          frame_err_d = 1'b0;
          if (ss_rise_s) state_d = S_RECV;
          else           state_d = S_IDLE;
        end
        S_RECV: begin
          if (word_cnt_q == CNT_FULL) begin
            state_d = S_HOLD;
          end else if (ss_fall_s) begin
            if (bit_cnt_q != {BIT_W{1'b0}}) frame_err_d = 1'b1;
            else                            frame_err_d = frame_err_q;
            bit_cnt_d = {BIT_W{1'b0}};
          end else if (sck_rise_s && ss_hi_s) begin
            shift_in_d = mem_wdata_s[SAMPLE_W-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              mem_we_s   = 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
              bit_cnt_d  = {BIT_W{1'b0}};
            end else begin
              bit_cnt_d  = bit_cnt_q + 1'b1;
            end
          end else begin
            state_d = S_RECV;
          end
        end
        S_HOLD: begin
          if (result_valid) begin
            tx_word_d = result_word;
            state_d   = S_ARM;
          end else begin
            state_d   = S_HOLD;
          end
        end
        S_ARM: begin
          if (ss_rise_s) begin
            state_d     = S_XMIT;
            shift_out_d = tx_word_q;
            bit_cnt_d   = {BIT_W{1'b0}};
          end else begin
            state_d     = S_ARM;
          end
        end
        S_XMIT: begin
          if ((bit_cnt_q == BIT_FULL) || ss_fall_s) begin
            state_d = S_IDLE;
          end else if (sck_fall_s) begin
            shift_out_d = {shift_out_q[WORD_W-2:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + 1'b1;
          end else begin
            state_d = S_XMIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered from next-state values so they align with the state flop.
    sdo_d         = (state_d == S_XMIT) ? shift_out_d[WORD_W-1] : 1'b0;
    input_ready_d = (state_d == S_HOLD);
    if ({1'b0, rd_addr} < CNT_FULL) rd_data_d = mem_q[rd_addr[MEM_AW-1:0]];
    else                            rd_data_d = {SAMPLE_W{1'b0}};
  end

  // Control, synchroniser and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sck_sync_q    <= 3'b000;
      ss_sync_q     <= 3'b000;
      sdi_sync_q    <= 2'b00;
      bit_cnt_q     <= {BIT_W{1'b0}};
      word_cnt_q    <= {(ADDR_W + 1){1'b0}};
      frame_err_q   <= 1'b0;
      shift_in_q    <= {(SAMPLE_W - 1){1'b0}};
      shift_out_q   <= {WORD_W{1'b0}};
      tx_word_q     <= {WORD_W{1'b0}};
      sdo_q         <= 1'b0;
      input_ready_q <= 1'b0;
      rd_data_q     <= {SAMPLE_W{1'b0}};
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      frame_err_q   <= frame_err_d;
      shift_in_q    <= shift_in_d;
      shift_out_q   <= shift_out_d;
      tx_word_q     <= tx_word_d;
      sdo_q         <= sdo_d;
      input_ready_q <= input_ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Sample memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[word_cnt_q[MEM_AW-1:0]] <= mem_wdata_s;
  end

  assign sdo         = sdo_q;
  assign rd_data     = rd_data_q;
  assign input_ready = input_ready_q;
  assign word_cnt    = word_cnt_q;
  assign frame_err   = frame_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Bench for spi_frame_buffer: a 4-sample 32/10-bit instance and a 16/16-bit
// instance share the SPI pins; each is checked only in its own scenarios.
module tb_spi_frame_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sck = 1'b0, sdi = 1'b0, ss = 1'b0, abort = 1'b0, result_valid = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] result_word_a = 32'h0;
  logic [15:0] result_word_b = 16'h0;

  logic        sdo_a, sdo_b, input_ready_a, input_ready_b, frame_err_a, frame_err_b;
  logic [9:0]  rd_data_a;
  logic [15:0] rd_data_b;
  logic [3:0]  word_cnt_a, word_cnt_b;
  logic [2:0]  state_a, state_b;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_RECV = 3'b001, ST_HOLD = 3'b010,
                         ST_ARM  = 3'b011, ST_XMIT = 3'b100;

  spi_frame_buffer #(.WORD_W(32), .SAMPLE_W(10), .NUM_SAMPLES(4), .ADDR_W(3)) dut_a (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ss(ss), .sdo(sdo_a),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data_a), .input_ready(input_ready_a),
    .result_valid(result_valid), .result_word(result_word_a), .word_cnt(word_cnt_a),
    .frame_err(frame_err_a), .state_dbg(state_a));

  spi_frame_buffer #(.WORD_W(16), .SAMPLE_W(16), .NUM_SAMPLES(4), .ADDR_W(3)) dut_b (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ss(ss), .sdo(sdo_b),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data_b), .input_ready(input_ready_b),
    .result_valid(result_valid), .result_word(result_word_b), .word_cnt(word_cnt_b),
    .frame_err(frame_err_b), .state_dbg(state_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [15:0] sample;
  } frame_vec_t;

  frame_vec_t  fv [16];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rx_a, rx_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] st(input int sel);
    return (sel == 0) ? state_a : state_b;
  endfunction

  function automatic logic [31:0] rd_sel(input int sel);
    return (sel == 0) ? {22'h0, rd_data_a} : {16'h0, rd_data_b};
  endfunction

  // Master transmit: sck period 8 clk, sdi changes 1 clk after each sck fall.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = w[i];
      tick(3);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_frame(input int base, input int nbits);
    for (int i = 0; i < 4; i++) send_bits(fv[base + i].word, nbits);
  endtask

  // Master receive: sample sdo of both instances at each sck rise.
  task automatic recv_bits(input int n, output logic [31:0] ra, output logic [31:0] rb);
    ra = 32'h0;
    rb = 32'h0;
    for (int i = 0; i < n; i++) begin
      tick(4);
      sck = 1'b1;
      ra = {ra[30:0], sdo_a};
      rb = {rb[30:0], sdo_b};
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic wait_state(input int sel, input logic [2:0] target, input int budget, input string name);
    int k = 0;
    while (st(sel) != target && k < budget) begin
      tick(1);
      k++;
    end
    check(name, {29'h0, st(sel)}, {29'h0, target});
  endtask

  // Sweep addresses 0..7; expected data is queued at drive time and popped one clk later.
  task automatic read_frame(input int base, input int sel);
    exp_q.delete();
    for (int a = 0; a < 8; a++) begin
      rd_addr = a[2:0];
      exp_q.push_back((a < 4) ? {16'h0, fv[base + a].sample} : 32'h0);
      tick(1);
      check($sformatf("rd_data[%0d] dut%0d", a, sel), rd_sel(sel), exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sdo"},         {31'h0, sdo_a},         32'h0);
    check({tag, " input_ready"}, {31'h0, input_ready_a}, 32'h0);
    check({tag, " rd_data"},     {22'h0, rd_data_a},     32'h0);
    check({tag, " word_cnt"},    {28'h0, word_cnt_a},    32'h0);
    check({tag, " frame_err"},   {31'h0, frame_err_a},   32'h0);
    check({tag, " state"},       {29'h0, state_a},       32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    fv[0]  = '{32'h0000_0155, 16'h0155};
    fv[1]  = '{32'h0000_03FF, 16'h03FF};
    fv[2]  = '{32'h0000_0000, 16'h0000};
    fv[3]  = '{32'hFFFF_F001, 16'h0001};
    fv[4]  = '{32'h1234_5678, 16'h0278};
    fv[5]  = '{32'hABCD_E3C1, 16'h03C1};
    fv[6]  = '{32'h0000_0200, 16'h0200};
    fv[7]  = '{32'h8000_00FF, 16'h00FF};
    fv[8]  = '{32'hDEAD_BEEF, 16'h02EF};
    fv[9]  = '{32'h0000_0001, 16'h0001};
    fv[10] = '{32'h5555_5555, 16'h0155};
    fv[11] = '{32'hAAAA_AAAA, 16'h02AA};
    fv[12] = '{32'h0000_BEEF, 16'hBEEF};
    fv[13] = '{32'h0000_0001, 16'h0001};
    fv[14] = '{32'h0000_FFFF, 16'hFFFF};
    fv[15] = '{32'h0000_8000, 16'h8000};

    tick(3);
    check_reset_outputs("por");
    reset = 1'b1;
    tick(2);

    // Full frame and readback including out-of-range addresses.
    ss = 1'b1;
    tick(4);
    check("enter recv", {29'h0, state_a}, {29'h0, ST_RECV});
    send_frame(0, 32);
    wait_state(0, ST_HOLD, 20, "frame1 hold");
    check("frame1 input_ready", {31'h0, input_ready_a}, 32'h1);
    check("frame1 word_cnt", {28'h0, word_cnt_a}, 32'd4);
    check("frame1 frame_err", {31'h0, frame_err_a}, 32'h0);
    ss = 1'b0;
    tick(4);
    check("hold ignores ss", {29'h0, state_a}, {29'h0, ST_HOLD});
    read_frame(0, 0);

    // Result return, including first-bit latency after ss rise.
    result_word_a = 32'h0000_02AA;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    check("arm after result", {29'h0, state_a}, {29'h0, ST_ARM});
    tick(4);
    ss = 1'b1;
    tick(2);
    check("arm before xmit", {29'h0, state_a}, {29'h0, ST_ARM});
    tick(1);
    check("xmit 3clk after ss", {29'h0, state_a}, {29'h0, ST_XMIT});
    recv_bits(32, rx_a, rx_b);
    check("result word rx", rx_a, 32'h0000_02AA);
    wait_state(0, ST_IDLE, 20, "idle after 32 bits");
    check("sdo idle", {31'h0, sdo_a}, 32'h0);
    ss = 1'b0;
    tick(4);

    // Mid-word select drop, then frame completes.
    ss = 1'b1;
    tick(4);
    send_bits(32'h0000_1ABC, 13);
    ss = 1'b0;
    tick(4);
    check("partial frame_err", {31'h0, frame_err_a}, 32'h1);
    check("partial word_cnt", {28'h0, word_cnt_a}, 32'h0);
    check("partial stays recv", {29'h0, state_a}, {29'h0, ST_RECV});
    ss = 1'b1;
    tick(4);
    send_frame(4, 32);
    wait_state(0, ST_HOLD, 20, "frame2 hold");
    check("frame2 frame_err sticky", {31'h0, frame_err_a}, 32'h1);
    check("frame2 word_cnt", {28'h0, word_cnt_a}, 32'd4);
    ss = 1'b0;
    tick(2);
    read_frame(4, 0);

    // Clean ss drop between words, then reset mid-frame.
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort from hold", {29'h0, state_a}, {29'h0, ST_IDLE});
    tick(2);
    ss = 1'b1;
    tick(4);
    check("frame_err cleared", {31'h0, frame_err_a}, 32'h0);
    send_bits(fv[4].word, 32);
    send_bits(fv[5].word, 32);
    ss = 1'b0;
    tick(4);
    check("clean drop no err", {31'h0, frame_err_a}, 32'h0);
    check("clean drop word_cnt", {28'h0, word_cnt_a}, 32'd2);
    ss = 1'b1;
    tick(4);
    send_bits(32'h5, 3);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    ss = 1'b0;
    sck = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    ss = 1'b1;
    tick(4);
    send_frame(8, 32);
    wait_state(0, ST_HOLD, 20, "frame3 hold");
    ss = 1'b0;
    tick(2);
    read_frame(8, 0);

    // result_valid coinciding with ss rise in HOLD: ARM must wait for a new rise.
    ss = 1'b1;
    tick(2);
    result_word_a = 32'hFFFF_FFFF;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    check("simul rise arm", {29'h0, state_a}, {29'h0, ST_ARM});
    tick(6);
    check("simul rise not consumed", {29'h0, state_a}, {29'h0, ST_ARM});
    ss = 1'b0;
    tick(4);
    ss = 1'b1;
    tick(2);
    check("sdo low before xmit", {31'h0, sdo_a}, 32'h0);
    tick(1);
    check("sdo msb at 3clk", {31'h0, sdo_a}, 32'h1);
    recv_bits(5, rx_a, rx_b);
    check("5 bits rx", rx_a, 32'h1F);
    check("sdo before abort", {31'h0, sdo_a}, 32'h1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort xmit state", {29'h0, state_a}, {29'h0, ST_IDLE});
    check("abort xmit sdo", {31'h0, sdo_a}, 32'h0);
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    tick(2);
    check("result_valid ignored idle", {29'h0, state_a}, {29'h0, ST_IDLE});
    check("idle input_ready", {31'h0, input_ready_a}, 32'h0);
    ss = 1'b0;
    tick(4);

    // 16-bit word / 16-bit sample instance.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    ss = 1'b1;
    tick(4);
    send_frame(12, 16);
    wait_state(1, ST_HOLD, 20, "b hold");
    check("b input_ready", {31'h0, input_ready_b}, 32'h1);
    check("b word_cnt", {28'h0, word_cnt_b}, 32'd4);
    ss = 1'b0;
    tick(2);
    read_frame(12, 1);
    result_word_b = 16'hC3A5;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    check("b arm", {29'h0, state_b}, {29'h0, ST_ARM});
    check("a ignores result in recv", {29'h0, state_a}, {29'h0, ST_RECV});
    tick(4);
    ss = 1'b1;
    tick(3);
    check("b xmit", {29'h0, state_b}, {29'h0, ST_XMIT});
    recv_bits(16, rx_a, rx_b);
    check("b result rx", {16'h0, rx_b[15:0]}, 32'h0000_C3A5);
    wait_state(1, ST_IDLE, 20, "b idle after 16 bits");
    ss = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
